req_encoder4: RTL and testbench

- Sequential counterpart of the team's 2-to-4 enable decoder.
- Collects one-hot/multi-hot request pulses from N sources into a pending register.
- Encodes the highest-index pending request to a binary index and presents it with a Valid/Ack handshake.
- Sits between button/event sources and a consumer that drives the decoder back to one-hot.

---
 rtl/req_encoder4_pkg.sv | 12 +
 rtl/prio_enc.sv | 22 ++
 rtl/req_encoder4.sv | 85 ++++++++
 tb/tb_req_encoder4.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/req_encoder4_pkg.sv
// Shared definitions for the request encoder: default sizes and FSM state encoding.
package req_encoder4_pkg;

  localparam int N_DEF = 4;
  localparam int W_DEF = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/prio_enc.sv
// Combinational highest-set-bit encoder: N request lines to a W-bit index plus any-set flag.
module prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  // Ascending scan so the last (highest) set bit overwrites lower ones.
  always_comb begin
    // NOTE: assign a default before the loop so no path leaves idx_o unassigned (no latch).
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i]) idx_o = W'(i);
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/req_encoder4.sv
// Collects request pulses into a pending register and grants them one at a time,
// highest index first, over a Valid/Ack handshake.
module req_encoder4
  import req_encoder4_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [N-1:0] req_i,
  input  logic         ack_i,
  output logic [W-1:0] y_o,
  output logic         valid_o,
  output logic [N-1:0] pending_o,
  output logic         drop_o
);

  state_e         state_q;
  logic [N-1:0]   pending_q, pending_d;
  logic [W-1:0]   y_q;
  logic           valid_q;
  logic           drop_q, drop_d;
  logic [N-1:0]   clr_mask;
  logic [W-1:0]   enc_idx;
  logic           any_pending;
  logic           accept;

  prio_enc #(.N(N), .W(W)) u_prio_enc (
    .req_i (pending_q),
    .idx_o (enc_idx),
    .any_o (any_pending)
  );

  assign accept = (state_q == ST_BUSY) && ack_i;

  // A request arriving on the accept edge for the granted bit re-sets it after the clear.
  always_comb begin
    clr_mask = '0;
    if (accept) clr_mask[y_q] = 1'b1;
    pending_d = (pending_q & ~clr_mask) | req_i;
    drop_d    = |(req_i & pending_q & ~clr_mask);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      y_q       <= '0;
      valid_q   <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      drop_q    <= drop_d;
      case (state_q)
        ST_IDLE: begin
          if (en_i && any_pending) begin
            y_q     <= enc_idx;
            valid_q <= 1'b1;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // En is ignored here: a presented grant is only retired by Ack.
          if (ack_i) begin
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign y_o       = y_q;
  assign valid_o   = valid_q;
  assign pending_o = pending_q;
  assign drop_o    = drop_q;

endmodule

// File: tb/tb_req_encoder4.sv
// Bench for req_encoder4: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural model.
module tb_req_encoder4;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         en_i;
  logic [N-1:0] req_i;
  logic         ack_i;
  logic [W-1:0] y_o;
  logic         valid_o;
  logic [N-1:0] pending_o;
  logic         drop_o;

  int checks   = 0;
  int failures = 0;

  req_encoder4 #(.N(N), .W(W)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (en_i),
    .req_i     (req_i),
    .ack_i     (ack_i),
    .y_o       (y_o),
    .valid_o   (valid_o),
    .pending_o (pending_o),
    .drop_o    (drop_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a set of outstanding requests and an optional granted index.
  typedef struct {
    logic [N-1:0] pend;
    logic         granted;
    int           gidx;
    logic         drop;
  } model_t;

  model_t m;

  function automatic int highest(input logic [N-1:0] p);
    for (int i = N - 1; i >= 0; i--) if (p[i]) return i;
    return -1;
  endfunction

  function automatic model_t model_next(input model_t s, input logic en, input logic ack,
                                        input logic [N-1:0] req);
    model_t n = s;
    logic [N-1:0] kept = s.pend;
    if (s.granted && ack) kept[s.gidx] = 1'b0;
    n.drop = (req & kept) != 0;
    n.pend = kept | req;
    if (s.granted) begin
      if (ack) n.granted = 1'b0;
    end else if (en && s.pend != 0) begin
      n.granted = 1'b1;
      n.gidx    = highest(s.pend);
    end
    return n;
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) m <= '{pend: '0, granted: 1'b0, gidx: 0, drop: 1'b0};
    else       m <= model_next(m, en_i, ack_i, req_i);
  end

  bit compare_on = 1'b0;

  always @(negedge clk_i) begin
    if (compare_on) begin
      check("model_valid",   {31'd0, valid_o}, {31'd0, m.granted});
      check("model_y",       {30'd0, y_o},     m.gidx);
      check("model_pending", {28'd0, pending_o}, {28'd0, m.pend});
      check("model_drop",    {31'd0, drop_o},  {31'd0, m.drop});
    end
  end

  // Apply inputs for one rising edge; returns 2 time units after that edge.
  task automatic step(input logic en, input logic ack, input logic [N-1:0] req);
    en_i  = en;
    ack_i = ack;
    req_i = req;
    @(posedge clk_i);
    #2;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [W-1:0] y,
                            input logic [N-1:0] p, input logic d);
    check({name, "_valid"},   {31'd0, valid_o},   {31'd0, v});
    if (v) check({name, "_y"}, {30'd0, y_o},      {30'd0, y});
    check({name, "_pending"}, {28'd0, pending_o}, {28'd0, p});
    check({name, "_drop"},    {31'd0, drop_o},    {31'd0, d});
  endtask

  initial begin
    rst_i = 1'b1;
    en_i  = 1'b0;
    ack_i = 1'b0;
    req_i = '0;
    @(posedge clk_i);
    @(posedge clk_i);
    #2;
    expect_out("reset_state", 1'b0, 2'd0, 4'b0000, 1'b0);
    check("reset_y", {30'd0, y_o}, 32'd0);
    rst_i = 1'b0;
    compare_on = 1'b1;

    // Single request
    step(1, 0, 4'b0100); expect_out("single_k",   0, 2'd0, 4'b0100, 0);
    step(1, 0, 4'b0000); expect_out("single_k1",  1, 2'd2, 4'b0100, 0);
    step(1, 0, 4'b0000); expect_out("single_k2",  1, 2'd2, 4'b0100, 0);
    step(1, 1, 4'b0000); expect_out("single_k3",  0, 2'd0, 4'b0000, 0);

    // Simultaneous requests, Ack held high
    step(1, 1, 4'b1011); expect_out("simul_cap",  0, 2'd0, 4'b1011, 0);
    step(1, 1, 4'b0000); expect_out("simul_g3",   1, 2'd3, 4'b1011, 0);
    step(1, 1, 4'b0000); expect_out("simul_i1",   0, 2'd0, 4'b0011, 0);
    step(1, 1, 4'b0000); expect_out("simul_g1",   1, 2'd1, 4'b0011, 0);
    step(1, 1, 4'b0000); expect_out("simul_i2",   0, 2'd0, 4'b0001, 0);
    step(1, 1, 4'b0000); expect_out("simul_g0",   1, 2'd0, 4'b0001, 0);
    step(1, 1, 4'b0000); expect_out("simul_end",  0, 2'd0, 4'b0000, 0);

    // Hold stability against a higher-priority arrival
    step(1, 0, 4'b0010);
    step(1, 0, 4'b0000); expect_out("hold_g1",    1, 2'd1, 4'b0010, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 4'b1000);
      check("hold_y_stable", {30'd0, y_o}, 32'd1);
      check("hold_valid",    {31'd0, valid_o}, 32'd1);
    end
    step(1, 1, 4'b0000); expect_out("hold_acc",   0, 2'd0, 4'b1000, 0);
    step(1, 0, 4'b0000); expect_out("hold_g3",    1, 2'd3, 4'b1000, 0);
    step(1, 1, 4'b0000);

    // Re-request coinciding with accept
    step(1, 0, 4'b0100);
    step(1, 0, 4'b0000); expect_out("rereq_g2",   1, 2'd2, 4'b0100, 0);
    step(1, 1, 4'b0100); expect_out("rereq_acc",  0, 2'd0, 4'b0100, 0);
    step(1, 0, 4'b0000); expect_out("rereq_g2b",  1, 2'd2, 4'b0100, 0);
    step(1, 1, 4'b0000);

    // Overrun while disabled, then enable
    step(0, 0, 4'b0001); expect_out("ovr_cap",    0, 2'd0, 4'b0001, 0);
    step(0, 0, 4'b0001); expect_out("ovr_drop",   0, 2'd0, 4'b0001, 1);
    step(0, 0, 4'b0000); expect_out("ovr_drop0",  0, 2'd0, 4'b0001, 0);
    step(1, 0, 4'b0000); expect_out("ovr_en",     1, 2'd0, 4'b0001, 0);
    step(1, 1, 4'b0000);

    // Ack while idle is ignored
    step(0, 0, 4'b0100);
    step(0, 1, 4'b0000); expect_out("idle_ack",   0, 2'd0, 4'b0100, 0);
    step(1, 0, 4'b0000);
    step(1, 1, 4'b0000);

    // Asynchronous reset mid-handshake
    step(1, 0, 4'b1010);
    step(1, 0, 4'b0000); expect_out("pre_rst",    1, 2'd3, 4'b1010, 0);
    #1;
    rst_i = 1'b1;
    #1;
    expect_out("async_rst", 0, 2'd0, 4'b0000, 0);
    check("async_rst_y", {30'd0, y_o}, 32'd0);
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 4'b0000);
      check("post_rst_valid", {31'd0, valid_o}, 32'd0);
    end

    // Randomized traffic checked by the per-cycle model compare
    for (int i = 0; i < 400; i++) begin
      logic         en_r;
      logic         ack_r;
      logic [N-1:0] req_r;
      en_r  = ($urandom_range(0, 3) != 0);
      ack_r = $urandom_range(0, 1) == 1;
      req_r = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      step(en_r, ack_r, req_r);
    end

    step(1, 1, 4'b0000);
    @(negedge clk_i);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
